// File: rtl/half_argmax_if.sv
// rtl/half_argmax_if.sv - request/result bundle for half_argmax; HALF_ARGMAX_SECOND_EN adds runner-up fields
interface half_argmax_if #(
    parameter int OUTPUT_NODES = 10,
    parameter int IDX_W        = $clog2(OUTPUT_NODES)
);
    logic             start;
    logic [15:0]      y [OUTPUT_NODES];
    logic             busy;
    logic             valid;
    logic [IDX_W-1:0] index;
    logic [15:0]      max_value;
    logic             all_nan;
`ifdef HALF_ARGMAX_SECOND_EN
    logic [IDX_W-1:0] second_index;
    logic [15:0]      second_value;
`endif

    modport master (
        output start, y,
        input  busy, valid, index, max_value, all_nan
`ifdef HALF_ARGMAX_SECOND_EN
        , input second_index, second_value
`endif
    );

    modport slave (
        input  start, y,
        output busy, valid, index, max_value, all_nan
`ifdef HALF_ARGMAX_SECOND_EN
        , output second_index, second_value
`endif
    );
endinterface

// File: rtl/half_argmax.sv
// rtl/half_argmax.sv - serial argmax over binary16 scores; HALF_ARGMAX_SECOND_EN adds runner-up tracking
module half_argmax #(
    parameter int OUTPUT_NODES = 10,
    parameter int IDX_W        = $clog2(OUTPUT_NODES)
) (
    input  logic          clk,
    input  logic          rstn,
    half_argmax_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(OUTPUT_NODES - 1);

    logic [1:0]       state;
    logic [15:0]      arr [OUTPUT_NODES];
    logic [IDX_W-1:0] cnt;
    logic [15:0]      best;
    logic [IDX_W-1:0] best_idx;
    logic             have_best;

    function automatic logic is_nan(input logic [15:0] b);
        return (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    endfunction

    // Maps binary16 onto an unsigned-comparable key, with -0 folded onto +0.
    function automatic logic [15:0] order_key(input logic [15:0] b);
        logic [15:0] n;
        n = (b == 16'h8000) ? 16'h0000 : b;
        return n[15] ? ~n : (n | 16'h8000);
    endfunction

    logic [15:0] elem;
    logic        elem_nan;
    logic        gt_best;

    assign elem     = arr[cnt];
    assign elem_nan = is_nan(elem);
    assign gt_best  = order_key(elem) > order_key(best);
    assign bus.busy = (state != IDLE);

`ifdef HALF_ARGMAX_SECOND_EN
    logic [15:0]      second;
    logic [IDX_W-1:0] second_idx;
    logic             have_second;
    logic             gt_second;

    assign gt_second = order_key(elem) > order_key(second);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            cnt           <= '0;
            best          <= '0;
            best_idx      <= '0;
            have_best     <= 1'b0;
            bus.valid     <= 1'b0;
            bus.index     <= '0;
            bus.max_value <= '0;
            bus.all_nan   <= 1'b0;
            for (int i = 0; i < OUTPUT_NODES; i++) arr[i] <= '0;
`ifdef HALF_ARGMAX_SECOND_EN
            second           <= '0;
            second_idx       <= '0;
            have_second      <= 1'b0;
            bus.second_index <= '0;
            bus.second_value <= '0;
`endif
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < OUTPUT_NODES; i++) arr[i] <= bus.y[i];
                        best      <= bus.y[0];
                        best_idx  <= '0;
                        have_best <= !is_nan(bus.y[0]);
                        cnt       <= IDX_W'(1);
                        state     <= SCAN;
`ifdef HALF_ARGMAX_SECOND_EN
                        second      <= '0;
                        second_idx  <= '0;
                        have_second <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    // NaN never displaces; a NaN seed is dropped by the first real value.
                    if (!elem_nan) begin
                        if (!have_best || gt_best) begin
                            best      <= elem;
                            best_idx  <= cnt;
                            have_best <= 1'b1;
`ifdef HALF_ARGMAX_SECOND_EN
                            if (have_best) begin
                                second      <= best;
                                second_idx  <= best_idx;
                                have_second <= 1'b1;
                            end
                        end else if (!have_second || gt_second) begin
                            second      <= elem;
                            second_idx  <= cnt;
                            have_second <= 1'b1;
`endif
                        end
                    end
                    cnt <= cnt + IDX_W'(1);
                    if (cnt == LAST) state <= DONE;
                end
                DONE: begin
                    bus.valid     <= 1'b1;
                    bus.index     <= best_idx;
                    bus.max_value <= best;
                    bus.all_nan   <= !have_best;
`ifdef HALF_ARGMAX_SECOND_EN
                    bus.second_index <= have_second ? second_idx : best_idx;
                    bus.second_value <= have_second ? second : best;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_half_argmax.sv
// tb/tb_half_argmax.sv - directed self-checking bench for half_argmax
module tb_half_argmax;
    localparam int N = 10;
    localparam int W = $clog2(N);

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [15:0] v [N];

    half_argmax_if #(.OUTPUT_NODES(N), .IDX_W(W)) bus ();

    half_argmax #(.OUTPUT_NODES(N), .IDX_W(W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [15:0] val);
        for (int i = 0; i < N; i++) v[i] = val;
    endtask

    task automatic drive_y();
        for (int i = 0; i < N; i++) bus.y[i] = v[i];
    endtask

    // Pulse start so that the next rising edge samples it; returns just after that edge.
    task automatic pulse_start();
        drive_y();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!bus.valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic count_valid(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid) n++;
        end
    endtask

    task automatic run(input string tag, input logic [W-1:0] idx, input logic [15:0] mv, input logic nan);
        int e;
        pulse_start();
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        fill(16'hDEAD);
        drive_y();
        wait_valid(e);
        check({tag, "_lat"}, 32'(e), 32'd10);
        check({tag, "_idx"}, 32'(bus.index), 32'(idx));
        check({tag, "_max"}, 32'(bus.max_value), 32'(mv));
        check({tag, "_nan"}, 32'(bus.all_nan), 32'(nan));
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(bus.valid), 32'd0);
    endtask

    initial begin
        int n;
        int e;
        bus.start = 1'b0;
        fill(16'h0000);
        drive_y();
        #12;
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_idx", 32'(bus.index), 32'd0);
        check("rst_max", 32'(bus.max_value), 32'd0);
        check("rst_nan", 32'(bus.all_nan), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        fill(16'h2E66); v[7] = 16'h3BF0;
        run("pos", 4'd7, 16'h3BF0, 1'b0);

        fill(16'hBC00); v[3] = 16'hB800;
        run("neg", 4'd3, 16'hB800, 1'b0);

        fill(16'h0000); v[2] = 16'h3C00; v[5] = 16'h3C00;
        run("tie", 4'd2, 16'h3C00, 1'b0);

        fill(16'hC000); v[0] = 16'h8000; v[1] = 16'h0000;
        run("zero", 4'd0, 16'h8000, 1'b0);

        fill(16'h0000); v[0] = 16'h7E00; v[4] = 16'h7C00; v[6] = 16'h3C00;
        run("inf", 4'd4, 16'h7C00, 1'b0);

        fill(16'h7E00);
        run("allnan", 4'd0, 16'h7E00, 1'b1);

        // start held for three sampling edges
        fill(16'h2E66); v[5] = 16'h3C00;
        drive_y();
        @(negedge clk);
        bus.start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b0;
        count_valid(30, n);
        check("hold_pulses", 32'(n), 32'd1);
        check("hold_idx", 32'(bus.index), 32'd5);

        // second start during scan with a different vector
        fill(16'h2E66); v[1] = 16'h3C00;
        pulse_start();
        repeat (2) @(posedge clk);
        fill(16'h2E66); v[8] = 16'h3C00;
        pulse_start();
        wait_valid(e);
        check("ign_lat", 32'(e), 32'd7);
        check("ign_idx", 32'(bus.index), 32'd1);
        count_valid(15, n);
        check("ign_pulses", 32'(n), 32'd0);

        // reset at scan edge 4
        fill(16'h2E66); v[6] = 16'h3C00;
        pulse_start();
        repeat (4) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_idx", 32'(bus.index), 32'd0);
        check("abort_max", 32'(bus.max_value), 32'd0);
        check("abort_valid", 32'(bus.valid), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        count_valid(20, n);
        check("abort_pulses", 32'(n), 32'd0);

        fill(16'h2E66); v[9] = 16'h3A00;
        run("fresh", 4'd9, 16'h3A00, 1'b0);

`ifdef HALF_ARGMAX_SECOND_EN
        fill(16'h2E66); v[7] = 16'h3BF0; v[1] = 16'h3A00;
        run("sec", 4'd7, 16'h3BF0, 1'b0);
        check("sec_idx", 32'(bus.second_index), 32'd1);
        check("sec_val", 32'(bus.second_value), 32'h3A00);

        fill(16'h7E00); v[9] = 16'h3C00;
        run("single", 4'd9, 16'h3C00, 1'b0);
        check("single_sidx", 32'(bus.second_index), 32'd9);
        check("single_sval", 32'(bus.second_value), 32'h3C00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
